// File: rtl/key_debounce_pkg.sv
// key_debounce_pkg: shared FSM state, key codes and counter sizing for the key debouncer
package key_pkg;
  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} key_state_t;
  localparam logic [1:0] KEY_NONE = 2'd0;
  localparam logic [1:0] KEY_G = 2'd1;
  localparam logic [1:0] KEY_F = 2'd2;
  localparam logic [1:0] KEY_E = 2'd3;
  function automatic int cnt_width(input int d, input int r);
    return $clog2((d > r ? d : r) + 1);
  endfunction
endpackage

// File: rtl/key_debounce_if.sv
// key_debounce_if: raw key inputs and debounced key events between a key source and the debouncer
interface key_debounce_if;
  logic [2:0] key_n;
  logic [2:0] key_level;
  logic [2:0] key_press;
  logic [2:0] key_release;
  logic [1:0] key_code;
  logic       key_valid;
  modport master (output key_n, input key_level, key_press, key_release, key_code, key_valid);
  modport slave (input key_n, output key_level, key_press, key_release, key_code, key_valid);
endinterface

// File: rtl/key_debounce_ch.sv
// key_debounce_ch: one-key synchronizer, qualification counter and press/release FSM (auto-repeat under KEY_AUTOREPEAT_EN)
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int REPEAT_CYCLES = 50_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_n,
  output logic level,
  output logic press,
  output logic rel
);
  localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_CYCLES);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  key_state_t state;
  logic pressed;
  assign pressed = ~sync[1];
  // two-flop synchronizer, resets to released
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) sync <= 2'b11;
    else sync <= {sync[0], key_n};
  // debounce FSM; level and pulses are registered with the state
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state <= IDLE;
      cnt <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel <= 1'b0;
    end else begin
      press <= 1'b0;
      rel <= 1'b0;
      case (state)
        IDLE:
          if (pressed) begin
            state <= PRESS_CHK;
            cnt <= '0;
          end
        PRESS_CHK:
          if (!pressed) state <= IDLE;
          else if (cnt == DB_LAST) begin
            state <= HELD;
            cnt <= '0;
            level <= 1'b1;
            press <= 1'b1;
          end else cnt <= cnt + 1'b1;
        HELD:
          if (!pressed) begin
            state <= REL_CHK;
            cnt <= '0;
          end
`ifdef KEY_AUTOREPEAT_EN
          else if (cnt == CW'(REPEAT_CYCLES - 1)) begin
            cnt <= '0;
            press <= 1'b1;
          end else cnt <= cnt + 1'b1;
`endif
        REL_CHK:
          if (pressed) begin
            state <= HELD;
            cnt <= '0;
          end else if (cnt == DB_LAST) begin
            state <= IDLE;
            level <= 1'b0;
            rel <= 1'b1;
          end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: rtl/key_debounce.sv
// key_debounce: three debounced keys (E,F,G) with press priority encoding; KEY_AUTOREPEAT_EN enables auto-repeat
module key_debounce
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int REPEAT_CYCLES = 50_000_000
) (
  input logic sys_clk,
  input logic sys_rst_n,
  key_debounce_if.slave bus
);
  logic [2:0] level, press, rel;
  logic [1:0] code;
  logic valid;
  for (genvar i = 0; i < 3; i++) begin : g_ch
    key_debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_ch (
      .sys_clk(sys_clk),
      .sys_rst_n(sys_rst_n),
      .key_n(bus.key_n[i]),
      .level(level[i]),
      .press(press[i]),
      .rel(rel[i])
    );
  end
  // strobe one cycle after any press; code keeps the highest pressed key until the next strobe
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      valid <= 1'b0;
      code <= KEY_NONE;
    end else begin
      valid <= |press;
      if (|press) code <= press[2] ? KEY_E : press[1] ? KEY_F : KEY_G;
    end
  assign bus.key_level = level;
  assign bus.key_press = press;
  assign bus.key_release = rel;
  assign bus.key_code = code;
  assign bus.key_valid = valid;
endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed self-checking bench for key_debounce with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8
module tb_key_debounce;
  logic clk = 1'b0;
  logic rst_n;
  int errors = 0;
  int checks = 0;
  int nv, np1, nr0;
  logic [2:0] seen_p;
`ifdef KEY_AUTOREPEAT_EN
  localparam int EXP_HOLD_PRESSES = 3;
`else
  localparam int EXP_HOLD_PRESSES = 1;
`endif
  key_debounce_if bus ();
  key_debounce #(.DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(8)) dut (
    .sys_clk(clk),
    .sys_rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
    seen_p |= bus.key_press;
    nv += int'(bus.key_valid);
    np1 += int'(bus.key_press[1]);
    nr0 += int'(bus.key_release[0]);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    nv = 0; np1 = 0; nr0 = 0; seen_p = '0;
    rst_n = 1'b0;
    bus.key_n = 3'b111;
    repeat (3) tick;
    chk("rst_level", bus.key_level, 0);
    chk("rst_press", bus.key_press, 0);
    chk("rst_release", bus.key_release, 0);
    chk("rst_code", bus.key_code, 0);
    chk("rst_valid", bus.key_valid, 0);
    rst_n = 1'b1;
    repeat (3) tick;
    // single key G: press lands on edge t+6
    bus.key_n = 3'b110;
    repeat (6) tick;
    chk("g_press_early", bus.key_press, 0);
    tick;
    chk("g_press", bus.key_press, 3'b001);
    chk("g_level", bus.key_level, 3'b001);
    chk("g_valid_lag", bus.key_valid, 0);
    tick;
    chk("g_press_once", bus.key_press, 0);
    chk("g_valid", bus.key_valid, 1);
    chk("g_code", bus.key_code, 1);
    tick;
    chk("g_valid_once", bus.key_valid, 0);
    tick;
    chk("g_level_hold", bus.key_level, 3'b001);
    chk("g_code_hold", bus.key_code, 1);
    bus.key_n = 3'b111;
    repeat (6) tick;
    chk("g_rel_early", bus.key_release, 0);
    chk("g_level_pre_rel", bus.key_level, 3'b001);
    tick;
    chk("g_release", bus.key_release, 3'b001);
    chk("g_level_clr", bus.key_level, 0);
    chk("g_no_press_at_rel", bus.key_press, 0);
    tick;
    chk("g_release_once", bus.key_release, 0);
    // 1-low/1-high glitch train must be rejected
    seen_p = '0;
    repeat (5) begin
      bus.key_n = 3'b110;
      tick;
      bus.key_n = 3'b111;
      tick;
    end
    repeat (8) tick;
    chk("glitch_press", seen_p, 0);
    chk("glitch_level", bus.key_level, 0);
    // E and G on the same edge
    nv = 0;
    bus.key_n = 3'b010;
    repeat (7) tick;
    chk("eg_press", bus.key_press, 3'b101);
    tick;
    chk("eg_valid", bus.key_valid, 1);
    chk("eg_code", bus.key_code, 3);
    repeat (3) tick;
    chk("eg_valid_count", nv, 1);
    bus.key_n = 3'b111;
    repeat (8) tick;
    chk("eg_level_clr", bus.key_level, 0);
    // release with a 2-cycle bounce
    bus.key_n = 3'b110;
    repeat (8) tick;
    chk("b_level_set", bus.key_level, 3'b001);
    bus.key_n = 3'b111;
    tick;
    bus.key_n = 3'b110;
    tick;
    nr0 = 0;
    bus.key_n = 3'b111;
    repeat (6) tick;
    chk("b_rel_early", bus.key_release, 0);
    tick;
    chk("b_release", bus.key_release, 3'b001);
    repeat (4) tick;
    chk("b_rel_count", nr0, 1);
    chk("b_level_clr", bus.key_level, 0);
    // reset while E is held and G is mid-qualification
    bus.key_n = 3'b011;
    repeat (8) tick;
    chk("r_level_e", bus.key_level, 3'b100);
    chk("r_code_e", bus.key_code, 3);
    bus.key_n = 3'b010;
    repeat (4) tick;
    #2 rst_n = 1'b0;
    #1;
    chk("r_async_level", bus.key_level, 0);
    chk("r_async_code", bus.key_code, 0);
    chk("r_async_press", bus.key_press, 0);
    tick;
    tick;
    rst_n = 1'b1;
    nv = 0;
    repeat (6) tick;
    chk("r_press_early", bus.key_press, 0);
    tick;
    chk("r_press", bus.key_press, 3'b101);
    tick;
    chk("r_code", bus.key_code, 3);
    chk("r_valid_count", nv, 1);
    // long hold of F: single press, or repeats every 8 cycles with auto-repeat
    bus.key_n = 3'b111;
    repeat (8) tick;
    chk("h_level_clr", bus.key_level, 0);
    np1 = 0;
    bus.key_n = 3'b101;
    repeat (30) tick;
    chk("h_press_count", np1, EXP_HOLD_PRESSES);
    chk("h_level", bus.key_level, 3'b010);
    chk("h_code", bus.key_code, 2);
    bus.key_n = 3'b111;
    repeat (8) tick;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 2_000_000, number of consecutive sys_clk cycles an input must hold a new level to be accepted (20 ms at 100 MHz); legal range 2..2^24-1.
REQ-002 Parameter REPEAT_CYCLES, default 50_000_000, hold period between auto-repeat press pulses; used only when KEY_AUTOREPEAT_EN is defined.
REQ-003 sys_clk  input  1  system clock, 100 MHz, all logic on rising edge.
REQ-004 sys_rst_n  input  1  asynchronous, active-low reset.
REQ-005 key_n  input  3  raw push-button levels, active-low, asynchronous to sys_clk; bit2=E, bit1=F, bit0=G.
REQ-006 key_level  output  3  debounced level per key, active-high (1 = held).
REQ-007 key_press  output  3  one-cycle pulse per key on accepted press (and on auto-repeat).
REQ-008 key_release  output  3  one-cycle pulse per key on accepted release.
REQ-009 key_code  output  2  registered encoded key of the most recent press pulse: 3=E, 2=F, 1=G, 0=none since reset.
REQ-010 key_valid  output  1  one-cycle strobe, asserted in the cycle after any key_press bit is set; key_code is valid in the same cycle.

Function
REQ-011 Each key_n bit shall pass through a 2-flop synchronizer before any other use; synchronizer flops reset to 1 (released).
REQ-012 Each channel shall run an independent FSM: IDLE, PRESS_CHK, HELD, REL_CHK.
REQ-013 IDLE: synchronized key pressed -> PRESS_CHK with counter cleared to 0; otherwise stay.
REQ-014 PRESS_CHK: synchronized key released -> IDLE (glitch rejected, no pulse); else counter increments; when counter reaches DEBOUNCE_CYCLES-1 while still pressed -> HELD, key_level bit set, key_press bit pulsed for exactly one cycle.
REQ-015 HELD: synchronized key released -> REL_CHK with counter cleared.
REQ-016 REL_CHK: key pressed again -> HELD (no pulse); else counter increments; at DEBOUNCE_CYCLES-1 -> IDLE, key_level bit cleared, key_release bit pulsed for one cycle.
REQ-017 Latency: key_n held at a stable new level from rising edge t shall produce the corresponding pulse and level change at rising edge t+2+DEBOUNCE_CYCLES.
REQ-018 Any bounce shorter than DEBOUNCE_CYCLES cycles shall produce no pulse and no key_level change.
REQ-019 Counter width shall be the minimum that holds max(DEBOUNCE_CYCLES, REPEAT_CYCLES); the counter shall never wrap.
REQ-020 Simultaneous press pulses: key_code shall take the highest-numbered key (E > F > G); key_valid still a single one-cycle strobe.
REQ-021 key_code shall hold its value until the next key_valid.
REQ-022 key_press and key_release for the same key shall never be asserted in the same cycle.

Reset
REQ-023 On sys_rst_n low, immediately and asynchronously: all FSMs IDLE, counters 0, key_level=3'b000, key_press=3'b000, key_release=3'b000, key_code=2'd0, key_valid=0, synchronizers 3'b111.
REQ-024 Reset asserted while a key is held shall discard that press; after release of reset the key is re-qualified as a fresh press (one new key_press after the debounce latency).

Configuration
REQ-025 Macro KEY_AUTOREPEAT_EN defined: in HELD the counter shall count to REPEAT_CYCLES-1, then pulse key_press (and key_valid/key_code) and restart, repeating while held; counter cleared on entry to HELD.
REQ-026 Macro KEY_AUTOREPEAT_EN undefined: exactly one key_press per accepted press; REPEAT_CYCLES ignored; no repeat logic synthesized.

Structure
REQ-027 Shared package key_pkg shall hold the FSM state typedef (IDLE, PRESS_CHK, HELD, REL_CHK) and the key_code constants (KEY_NONE=0, KEY_G=1, KEY_F=2, KEY_E=3).
REQ-028 Sub-module key_debounce_ch shall implement synchronizer, counter and FSM for one key; key_debounce instantiates three and adds the priority encoder and key_valid/key_code registers.

Verification (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8)
REQ-029 key_n=3'b110 held 10 cycles -> key_press=3'b001 one cycle at edge t+6, key_code=1, key_valid one cycle later; key_level[0]=1 until release qualifies.
REQ-030 key_n bit0 toggling 1 cycle low / 1 cycle high for 5 periods -> no key_press, key_level stays 3'b000.
REQ-031 key_n=3'b010 (E and G pressed on the same edge) held -> key_press=3'b101 in one cycle, key_code=3, single key_valid.
REQ-032 Held key released with 2-cycle bounce then stable high -> exactly one key_release pulse, 4 cycles after the last bounce edge plus 2.
REQ-033 sys_rst_n pulsed low mid-PRESS_CHK with key held -> all outputs 0 immediately; one key_press 6 cycles after reset release.
REQ-034 KEY_AUTOREPEAT_EN defined, key held 30 cycles -> initial press pulse, then a repeat key_press every 8 cycles while held; undefined -> single pulse only.
